// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID register. Keeps at most one imem request in flight,
// parks a response in a hold buffer while the hazard unit stalls, and discards responses after a redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_valid_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        drop_q, drop_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;

    logic        issue;
    logic        deliver;
    logic [31:0] dlv_pc;
    logic [31:0] dlv_instr;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        drop_d       = drop_q;
        issue        = 1'b0;
        deliver      = 1'b0;
        dlv_pc       = hold_pc_q;
        dlv_instr    = hold_instr_q;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    pc_d = redirect_pc_i;
                end else begin
                    issue   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!imem_valid_i) begin
                    // The in-flight word belongs to the old path; remember to discard it.
                    if (flush_i) begin
                        drop_d = 1'b1;
                        pc_d   = redirect_pc_i;
                    end
                end else if (drop_q) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                    if (flush_i) pc_d = redirect_pc_i;
                end else if (flush_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = IDLE;
                end else if (stall_i) begin
                    hold_pc_d    = req_pc_q;
                    hold_instr_d = imem_rdata_i;
                    state_d      = HOLD;
                end else begin
                    deliver   = 1'b1;
                    dlv_pc    = req_pc_q;
                    dlv_instr = imem_rdata_i;
                    issue     = 1'b1;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = IDLE;
                end else if (!stall_i) begin
                    deliver = 1'b1;
                    issue   = 1'b1;
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
    end

    always_comb begin
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        if (flush_i) begin
            if_pc_d    = 32'd0;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else if (stall_i) begin
            if_valid_d = if_valid_q;
        end else if (deliver) begin
            if_pc_d    = dlv_pc;
            if_instr_d = dlv_instr;
            if_valid_d = 1'b1;
        end else begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= NOP_INSTR;
            drop_q       <= 1'b0;
            if_pc_q      <= 32'd0;
            if_instr_q   <= NOP_INSTR;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            drop_q       <= drop_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_valid_q   <= if_valid_d;
        end
    end

    // Request is a Mealy output of the IDLE state, so mask it while reset is held.
    assign imem_req_o  = issue & rst_ni;
    assign imem_addr_o = pc_q;
    assign pc_o        = if_pc_q;
    assign pc4_o       = if_pc_q + 32'd4;
    assign instr_o     = if_instr_q;
    assign valid_o     = if_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory model, directed scenarios, then random
// stall/flush/latency traffic checked against an instruction-stream scoreboard.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic [31:0] pc, pc4, instr;
    logic        valid;

    int          n_checks = 0;
    int          n_pass = 0;
    int          lat = 1;
    int          deliveries = 0;
    logic [63:0] exp_q[$];

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_pc_i(redirect), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .imem_valid_i(imem_valid),
        .pc_o(pc), .pc4_o(pc4), .instr_o(instr), .valid_o(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model plus request-address checker (sequential, restarting at each redirect).
    initial begin : mem_proc
        bit          req_seen, valid_seen, busy;
        logic [31:0] addr_seen, maddr, req_next;
        int          cnt;
        busy = 0; cnt = 0; maddr = 0; req_next = RESET_PC;
        forever begin
            @(negedge clk);
            req_seen = imem_req; addr_seen = imem_addr; valid_seen = imem_valid;
            if (!rst_n) begin
                req_next = RESET_PC;
            end else begin
                if (flush) chk1("no_req_on_flush", req_seen, 1'b0);
                if (req_seen) begin
                    chk("req_addr", addr_seen, req_next);
                    req_next = req_next + 32'd4;
                end
                if (flush) req_next = redirect;
            end
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (!rst_n) begin
                busy = 0;
                continue;
            end
            if (valid_seen) busy = 0;
            if (req_seen) begin
                chk1("one_outstanding", busy, 1'b0);
                busy = 1; maddr = addr_seen; cnt = lat;
            end
            if (busy && cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = maddr | 32'h13;
                end
            end
        end
    end

    // Monitor: judges the effect of each clock edge on IF/ID against the expected stream.
    initial begin : monitor
        bit          have_prev, p_flush, p_stall, last_valid;
        logic [31:0] p_redirect, next_pc, last_pc, last_instr;
        logic [63:0] e;
        have_prev = 0; last_valid = 0; next_pc = RESET_PC;
        p_flush = 0; p_stall = 0; p_redirect = 0; last_pc = 0; last_instr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete(); next_pc = RESET_PC; have_prev = 0; last_valid = 0;
            end else begin
                if (have_prev) begin
                    if (p_flush) begin
                        chk1("flush_valid", valid, 1'b0);
                        chk("flush_instr", instr, NOP);
                        chk("flush_pc", pc, 32'd0);
                        exp_q.delete(); next_pc = p_redirect; last_valid = 0;
                    end else if (p_stall) begin
                        if (last_valid) begin
                            chk1("stall_valid", valid, 1'b1);
                            chk("stall_pc", pc, last_pc);
                            chk("stall_instr", instr, last_instr);
                        end
                    end else if (valid) begin
                        while (exp_q.size() < 4) begin
                            exp_q.push_back({next_pc, next_pc | 32'h13});
                            next_pc = next_pc + 32'd4;
                        end
                        e = exp_q.pop_front();
                        chk("dlv_pc", pc, e[63:32]);
                        chk("dlv_instr", instr, e[31:0]);
                        last_valid = 1; last_pc = e[63:32]; last_instr = e[31:0];
                        deliveries++;
                    end else begin
                        chk("bubble_instr", instr, NOP);
                        last_valid = 0;
                    end
                    chk("pc4", pc4, pc + 32'd4);
                end
                p_flush = flush; p_stall = stall; p_redirect = redirect; have_prev = 1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit found;
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_valid", valid, 1'b0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc4, 32'd4);
        chk1("rst_req", imem_req, 1'b0);

        // Reset release with 1-cycle memory, then a 3-cycle stall over the 0x8 response.
        lat = 1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); chk1("c0_req", imem_req, 1'b1); chk("c0_addr", imem_addr, 32'h0); chk1("c0_valid", valid, 1'b0);
        step(); @(negedge clk); chk1("c1_req", imem_req, 1'b1); chk("c1_addr", imem_addr, 32'h4); chk1("c1_valid", valid, 1'b0);
        step(); @(negedge clk); chk1("c2_req", imem_req, 1'b1); chk("c2_addr", imem_addr, 32'h8);
        chk1("c2_valid", valid, 1'b1); chk("c2_pc", pc, 32'h0); chk("c2_instr", instr, 32'h13);
        step(); stall = 1'b1;
        @(negedge clk); chk1("s0_req", imem_req, 1'b0); chk("s0_pc", pc, 32'h4);
        step(); @(negedge clk); chk1("s1_req", imem_req, 1'b0); chk("s1_pc", pc, 32'h4);
        step(); @(negedge clk); chk1("s2_req", imem_req, 1'b0); chk("s2_pc", pc, 32'h4);
        step(); stall = 1'b0;
        @(negedge clk); chk1("s3_req", imem_req, 1'b1); chk("s3_addr", imem_addr, 32'hC); chk("s3_pc", pc, 32'h4);
        step(); @(negedge clk); chk("s4_pc", pc, 32'h8); chk("s4_instr", instr, 32'h1B);
        step(); @(negedge clk); chk("s5_pc", pc, 32'hC);

        // Flush while a 3-cycle request is outstanding.
        lat = 3;
        repeat (4) step();
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_valid) begin found = 1; break; end
        end
        chk1("lat3_resp_seen", found, 1'b1);
        step(); flush = 1'b1; redirect = 32'h100;
        step(); flush = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin found = 1; break; end
            chk1("drop_valid", valid, 1'b0);
        end
        chk1("redir_req_seen", found, 1'b1);
        chk("redir_req_addr", imem_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) begin found = 1; break; end
        end
        chk1("redir_arrive", found, 1'b1);
        chk("redir_pc", pc, 32'h100);

        // Flush, stall and a response all in the same cycle.
        lat = 1;
        repeat (6) step();
        step(); flush = 1'b1; stall = 1'b1; redirect = 32'h100;
        step(); flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("fs_instr", instr, NOP); chk1("fs_valid", valid, 1'b0); chk("fs_pc", pc, 32'h0);
        chk1("fs_req", imem_req, 1'b1); chk("fs_addr", imem_addr, 32'h100);

        // Address wrap at the top of the address space.
        repeat (4) step();
        step(); flush = 1'b1; redirect = 32'hFFFF_FFF8;
        step(); flush = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid && pc == 32'hFFFF_FFFC) begin found = 1; break; end
        end
        chk1("wrap_top_seen", found, 1'b1);
        chk("wrap_pc4", pc4, 32'h0);
        step(); @(negedge clk);
        chk1("wrap_valid", valid, 1'b1); chk("wrap_pc", pc, 32'h0);

        // Asynchronous reset in the middle of streaming.
        repeat (3) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk1("arst_valid", valid, 1'b0); chk("arst_instr", instr, NOP);
        chk("arst_pc", pc, 32'h0); chk1("arst_req", imem_req, 1'b0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk1("arst_rel_req", imem_req, 1'b1); chk("arst_rel_addr", imem_addr, RESET_PC);

        // Random traffic.
        d0 = deliveries;
        for (int i = 0; i < 2000; i++) begin
            step();
            lat   = $urandom_range(1, 4);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            else redirect = $urandom & 32'hFFFF_FFFC;
        end
        step(); stall = 1'b0; flush = 1'b0;
        repeat (12) step();
        chk1("liveness", (deliveries - d0) > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
